// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-channel synchronizer, debouncer and press/release pulse generator
// Each channel: 2-flop sync, polarity normalize, 4-state debounce FSM with a shared hold counter.
module button_debounce #(
  parameter int NUM_INPUTS    = 2,
  parameter int STABLE_CYCLES = 502_500,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] btn_raw,
  output logic [NUM_INPUTS-1:0] btn_level,
  output logic [NUM_INPUTS-1:0] btn_press,
  output logic [NUM_INPUTS-1:0] btn_release,
  output logic                  btn_event
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debounce: STABLE_CYCLES must be 2 or more");
  end
  if (NUM_INPUTS < 1 || NUM_INPUTS > 8) begin : g_bad_inputs
    $error("button_debounce: NUM_INPUTS must be in 1..8");
  end

  typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_t;

  logic [NUM_INPUTS-1:0] sync1;
  logic [NUM_INPUTS-1:0] sync2;
  logic [NUM_INPUTS-1:0] s;

  // Sync flops idle at the released pin level so nothing looks pressed out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= {NUM_INPUTS{ACTIVE_LOW_IN}};
      sync2 <= {NUM_INPUTS{ACTIVE_LOW_IN}};
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ {NUM_INPUTS{ACTIVE_LOW_IN}};

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          press_p;
    logic          rel_p;

    // The count of matching samples includes the entry cycle, so expiry is at LAST.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= REL;
        cnt     <= '0;
        level   <= 1'b0;
        press_p <= 1'b0;
        rel_p   <= 1'b0;
      end else begin
        press_p <= 1'b0;
        rel_p   <= 1'b0;
        case (state)
          REL: begin
            if (s[i]) begin
              state <= CHK_P;
              cnt   <= CW'(1);
            end
          end
          CHK_P: begin
            if (!s[i]) begin
              state <= REL;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state   <= PRS;
              level   <= 1'b1;
              press_p <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PRS: begin
            if (!s[i]) begin
              state <= CHK_R;
              cnt   <= CW'(1);
            end
          end
          CHK_R: begin
            if (s[i]) begin
              state <= PRS;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= REL;
              level <= 1'b0;
              rel_p <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= REL;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level;
    assign btn_press[i]   = press_p;
    assign btn_release[i] = rel_p;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_event <= 1'b0;
    end else begin
      btn_event <= |{btn_press, btn_release};
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized and directed bench for button_debounce
// Reference model tracks run lengths of the delayed, normalized pin value per channel.
module tb_button_debounce;

  localparam int NI = 2;
  localparam int SC = 4;

  logic          clk;
  logic          reset_n;
  logic [NI-1:0] btn_raw;
  logic [NI-1:0] btn_level;
  logic [NI-1:0] btn_press;
  logic [NI-1:0] btn_release;
  logic          btn_event;

  button_debounce #(
    .NUM_INPUTS   (NI),
    .STABLE_CYCLES(SC),
    .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_event  (btn_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: pin pipeline two edges deep, then a run counter per channel.
  logic [NI-1:0] m_p1, m_p2, m_level, m_press, m_rel;
  logic          m_event;
  int            m_run [NI];

  logic [NI-1:0] o_level, o_press, o_rel;
  logic          o_event;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = '1; m_p2 = '1;
    m_level = '0; m_press = '0; m_rel = '0; m_event = 1'b0;
    for (int c = 0; c < NI; c++) m_run[c] = 0;
  endtask

  task automatic model_edge(input logic [NI-1:0] raw, input logic rstn);
    logic          ev;
    logic          smp;
    if (!rstn) begin
      model_reset();
      return;
    end
    ev = |{m_press, m_rel};
    for (int c = 0; c < NI; c++) begin
      smp = ~m_p2[c];
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (smp != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == SC) begin
          m_level[c] = smp;
          if (smp) m_press[c] = 1'b1;
          else     m_rel[c]   = 1'b1;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_event = ev;
    m_p2 = m_p1;
    m_p1 = raw;
  endtask

  // Called aligned to a falling edge; returns aligned to the next falling edge.
  task automatic tick(input logic [NI-1:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw, reset_n);
    #1;
    o_level = btn_level; o_press = btn_press; o_rel = btn_release; o_event = btn_event;
    check("outs", {1'b0, o_event, o_rel, o_press, o_level},
                  {1'b0, m_event, m_rel, m_press, m_level});
    @(negedge clk);
  endtask

  // Ticks with a fixed pin value until the chosen pulse appears; n = ticks taken, -1 on timeout.
  task automatic wait_pulse(input logic [NI-1:0] raw, input bit is_rel, input int ch, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(raw);
      if ((is_rel ? o_rel[ch] : o_press[ch]) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int cnt;

  initial begin
    reset_n = 1'b0;
    btn_raw = '1;
    model_reset();
    @(negedge clk);

    // Reset idle
    repeat (3) tick(2'b11);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(2'b11);
      cnt += $countones({o_level, o_press, o_rel, o_event});
    end
    check("idle_outputs", 8'(cnt), 8'd0);

    // Clean press and release on channel 0
    wait_pulse(2'b10, 1'b0, 0, n);
    check("press_latency", 8'(n), 8'd6);
    check("press_level", 8'(o_level), 8'b01);
    tick(2'b10);
    check("press_event", 8'(o_event), 8'd1);
    check("press_width", 8'(o_press), 8'd0);
    repeat (4) tick(2'b10);
    wait_pulse(2'b11, 1'b1, 0, n);
    check("release_latency", 8'(n), 8'd6);
    check("release_level", 8'(o_level), 8'b00);
    repeat (6) tick(2'b11);

    // Bounce rejection
    cnt = 0;
    for (int w = 1; w <= 3; w++) begin
      repeat (w) begin tick(2'b10); cnt += int'(o_press[0]); end
      repeat (2) begin tick(2'b11); cnt += int'(o_press[0]); end
    end
    repeat (4) begin tick(2'b11); cnt += int'(o_press[0]); end
    check("bounce_no_press", 8'(cnt), 8'd0);
    wait_pulse(2'b10, 1'b0, 0, n);
    check("bounce_latency", 8'(n), 8'd6);
    cnt = 0;
    repeat (10) begin tick(2'b10); cnt += int'(o_press[0]); end
    check("bounce_single", 8'(cnt), 8'd0);

    // Simultaneous channels
    repeat (10) tick(2'b11);
    wait_pulse(2'b00, 1'b0, 0, n);
    check("simul_latency", 8'(n), 8'd6);
    check("simul_press", 8'(o_press), 8'b11);
    cnt = 0;
    repeat (4) begin tick(2'b00); cnt += int'(o_event); end
    check("simul_event_count", 8'(cnt), 8'd1);

    // Reset with channel 1 pressed and channel 0 mid-count toward release
    repeat (3) tick(2'b01);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("reset_async", {1'b0, btn_event, btn_release, btn_press, btn_level}, 8'd0);
    @(negedge clk);
    repeat (3) tick(2'b00);
    reset_n = 1'b1;
    wait_pulse(2'b00, 1'b0, 1, n);
    check("post_reset_latency", 8'(n), 8'd6);
    check("post_reset_press", 8'(o_press), 8'b11);

    // Long hold on channel 1
    repeat (10) tick(2'b11);
    cnt = 0;
    repeat (1000) begin tick(2'b01); cnt += int'(o_press[1]); end
    check("long_hold_presses", 8'(cnt), 8'd1);
    check("long_hold_level", 8'(o_level[1]), 8'd1);

    // Random segments: pin values held for 1..7 cycles
    for (int k = 0; k < 300; k++) begin
      logic [NI-1:0] r;
      r = NI'($urandom);
      repeat ($urandom_range(1, 7)) tick(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
